// File: rtl/ram64_frame_writer.sv
// Packs a framed byte stream into one ping-pong page of the 64x8 RAM write port,
// then commits the finished page to the readers with a FRM_RDY/FRM_ACK handshake.
module ram64_frame_writer #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int MAX_LEN = 31
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] S_DATA,
    input  logic              S_VALID,
    input  logic              S_SOF,
    input  logic              S_EOF,
    output logic              S_READY,
    output logic [ADDR_W-1:0] C_ADDR,
    output logic [DATA_W-1:0] C_DIN,
    output logic              C_WEN,
    output logic              RD_PAGE,
    output logic              FRM_RDY,
    output logic [ADDR_W-2:0] FRM_LEN,
    input  logic              FRM_ACK,
    output logic              ERR_OVF,
    output logic              ERR_ABT
);
    localparam int OFF_W = ADDR_W - 1;
    localparam logic [OFF_W-1:0] MAX_C = OFF_W'(MAX_LEN);
    localparam logic [OFF_W-1:0] ONE   = OFF_W'(1);

    typedef enum logic [2:0] {IDLE, RECV, DISCARD, HDR, COMMIT, WAIT_ACK} state_t;

    state_t             state, state_d;
    logic [OFF_W-1:0]   cnt, cnt_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  din_d;
    logic [ADDR_W-2:0]  len_d;
    logic               wen_d, page_d, rdy_d, ovf_d, abt_d;
    logic               xfer, start, commit, wp;

    assign S_READY = !RST && (state == IDLE || state == RECV || state == DISCARD);
    assign xfer    = S_VALID && S_READY;
    // Always fill the page the readers are not holding.
    assign wp      = ~RD_PAGE;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        wen_d   = 1'b0;
        addr_d  = C_ADDR;
        din_d   = C_DIN;
        ovf_d   = 1'b0;
        abt_d   = 1'b0;
        page_d  = RD_PAGE;
        rdy_d   = FRM_RDY;
        len_d   = FRM_LEN;
        start   = 1'b0;
        commit  = 1'b0;

        if (FRM_ACK && FRM_RDY) rdy_d = 1'b0;

        case (state)
            IDLE: if (xfer && S_SOF) start = 1'b1;
            DISCARD: if (xfer) begin
                if (S_SOF)      start   = 1'b1;
                else if (S_EOF) state_d = IDLE;
            end
            RECV: if (xfer) begin
                if (S_SOF) begin
                    start = 1'b1;
                    abt_d = 1'b1;
                end else if (cnt < MAX_C) begin
                    wen_d  = 1'b1;
                    addr_d = {wp, cnt + ONE};
                    din_d  = S_DATA;
                    cnt_d  = cnt + ONE;
                    if (S_EOF) state_d = HDR;
                end else begin
                    ovf_d   = 1'b1;
                    state_d = S_EOF ? IDLE : DISCARD;
                end
            end
            HDR: begin
                wen_d   = 1'b1;
                addr_d  = {wp, {OFF_W{1'b0}}};
                din_d   = DATA_W'(cnt);
                state_d = COMMIT;
            end
            COMMIT: if (!FRM_RDY || FRM_ACK) commit = 1'b1;
                    else                     state_d = WAIT_ACK;
            WAIT_ACK: if (FRM_ACK) commit = 1'b1;
            default: state_d = IDLE;
        endcase

        if (start) begin
            wen_d   = 1'b1;
            addr_d  = {wp, ONE};
            din_d   = S_DATA;
            cnt_d   = ONE;
            state_d = S_EOF ? HDR : RECV;
        end

        // A commit overrides any ACK-driven clear: the new page is immediately ready.
        if (commit) begin
            page_d  = ~RD_PAGE;
            rdy_d   = 1'b1;
            len_d   = cnt;
            state_d = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            C_WEN   <= 1'b0;
            C_ADDR  <= '0;
            C_DIN   <= '0;
            RD_PAGE <= 1'b0;
            FRM_RDY <= 1'b0;
            FRM_LEN <= '0;
            ERR_OVF <= 1'b0;
            ERR_ABT <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            C_WEN   <= wen_d;
            C_ADDR  <= addr_d;
            C_DIN   <= din_d;
            RD_PAGE <= page_d;
            FRM_RDY <= rdy_d;
            FRM_LEN <= len_d;
            ERR_OVF <= ovf_d;
            ERR_ABT <= abt_d;
        end
    end
endmodule
